fp16_div_seq: RTL and testbench
===============================

Name: fp16_div_seq

Overview:
- Iterative FP16 divider. Computes Result = A / B for half-precision operands.
- Complements the combinational FP add/sub/mul ALU. It provides the inverse of FMUL as a multi-cycle unit with a start/done handshake.
- Uses the same number format as the ALU:
  - sign[15], exp[14:10] with bias 15, mantissa[9:0] with implicit leading 1;
  - no subnormals, NaN or rounding; results are truncated.
- Sits beside the ALU in the FP execute stage. The controller stalls on busy.

Parameters:
- EXP_W, 5, exponent width; only the default is supported.
- MAN_W, 10, stored mantissa width; only the default is supported.
- BIAS, 15, exponent bias.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- A  in  16  dividend (FP16).
- B  in  16  divisor (FP16).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; Result and flags are valid from this cycle on.
- Result  out  16  quotient (FP16), registered.
- Zero  out  1  Result == 16'h0000 or 16'h8000.
- DivZero  out  1  B exponent was 0.
- Overflow  out  1  exponent saturated to infinity.
- Underflow  out  1  exponent flushed to zero.

Behaviour:
- Reset: state=IDLE; busy, done, Result, Zero, DivZero, Overflow and Underflow are all 0. rst mid-operation aborts immediately and no done is produced.
- States: IDLE, CALC, NORM, DONE.
- IDLE:
  - start=1 captures A and B into registers, with sR = A[15]^B[15].
  - Special cases go IDLE->DONE; all others go IDLE->CALC.
- Special cases, checked in priority order:
  - B exp==0: Result={sR,5'h1F,10'h0}, DivZero=1.
  - A exp==0: Result={sR,15'h0}, Zero=1.
- Exponent: 7-bit signed eR = expA - expB + 15, computed at capture.
- CALC, exactly 12 cycles (counter 0..11), restoring division:
  - Initialisation: R(12b) = {1'b0,1,manA}; D = {1,manB}.
  - Each cycle:
    - if R >= D, then q bit = 1 and R = R - D; otherwise q bit = 0;
    - then R = R << 1;
    - q fills MSB-first into q[11:0].
  - CALC->NORM after the count-11 cycle.
- NORM, one cycle:
  - q[11]=1: man = q[10:1].
  - q[11]=0: man = q[9:0] and eR = eR - 1. q[10] is guaranteed 1 in this case.
  - Then:
    - eR >= 31: Result = {sR,5'h1F,10'h0}, Overflow=1.
    - eR <= 0: Result = {sR,15'h0}, Underflow=1, Zero=1.
    - otherwise: Result = {sR, eR[4:0], man}.
  - NORM->DONE.
- DONE: done=1 for exactly one cycle, then ->IDLE. busy is still 1 during DONE.
- Latency, with start sampled at edge k:
  - normal: done high in the cycle following edge k+14;
  - special case: done high after edge k+1.
  - Back-to-back: a new start is accepted the first IDLE cycle after DONE.
- start while busy: ignored, with no effect on the operands or the result.
- Changes to A or B after capture: no effect.
- Outputs hold:
  - Result and all flags hold until the next captured operation reaches DONE.
  - The flags are cleared at the next accepted start, then set again by that operation.
- Flag exclusivity: DivZero, Overflow and Underflow are mutually exclusive.

Test Plan:
- A=3C00 (1.0), B=3C00, start pulse -> done 14 cycles later, Result=3C00, all flags 0; busy high from the cycle after start through done.
- A=4600 (6.0), B=4000 (2.0) -> Result=4200 (3.0). Then A=3C00, B=4200 -> Result=3555 (1/3, truncated; exercises the q[11]=0 normalize path).
- A=C000 (-2.0), B=3800 (0.5) -> Result=C400 (-4.0). Repeat with A=4000, B=B800 -> C400.
- A=3C00, B=0000 -> done 1 cycle after start, Result=7C00, DivZero=1. Also A=0000, B=4000 -> Result=0000, Zero=1, done after 1 cycle.
- A=7800, B=0400 -> Result=7C00, Overflow=1. A=0400, B=7800 -> Result=0000, Underflow=1, Zero=1.
- Busy/reset behaviour:
  - start with new operands during CALC -> ignored, and the first result is unchanged.
  - rst asserted in CALC cycle 5 -> next cycle busy=0 and Result=0, with no done pulse.
  - A fresh start then completes normally.

Source files
------------

// File: rtl/fp16_div_seq.sv
// ---------------------------------------------------------------------------
// fp16_div_seq
//   Iterative half-precision divider, Result = A / B. It is the multi-cycle
//   counterpart of the combinational FP multiplier. The number format has no
//   subnormals, NaN or rounding, and quotients are truncated.
//   The quotient mantissa comes from a 12-step restoring division.
//   Operands with a zero exponent are resolved at capture and bypass it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts any operation in flight
//   start      request, only looked at while idle
//   A, B       dividend / divisor (FP16), captured on an accepted start
//   busy       high whenever the unit is not idle (including the done cycle)
//   done       one-cycle pulse; Result and flags are valid from this cycle on
//   Result     registered quotient
//   Zero       Result is +0 or -0
//   DivZero    divisor exponent was zero
//   Overflow   exponent saturated to infinity
//   Underflow  exponent flushed to zero
// ---------------------------------------------------------------------------
module fp16_div_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BIAS  = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [EXP_W+MAN_W:0]       A,
  input  logic [EXP_W+MAN_W:0]       B,
  output logic                       busy,
  output logic                       done,
  output logic [EXP_W+MAN_W:0]       Result,
  output logic                       Zero,
  output logic                       DivZero,
  output logic                       Overflow,
  output logic                       Underflow
);

  localparam int FW = 1 + EXP_W + MAN_W;  // full word width
  localparam int QW = MAN_W + 2;          // remainder / quotient width
  localparam int EW = EXP_W + 2;          // signed working exponent width

  localparam logic [3:0]              LAST_STEP = 4'(QW - 1);
  localparam logic signed [EW-1:0]    E_SAT     = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0]    E_ZERO    = '0;
  localparam logic signed [EW-1:0]    E_ONE     = EW'(1);
  localparam logic signed [EW-1:0]    E_BIAS    = EW'(BIAS);
  localparam logic [EXP_W-1:0]        EXP_INF   = '1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_NORM, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [QW-1:0]            rem_q, rem_d;
  logic [MAN_W:0]           div_q, div_d;
  logic [QW-1:0]            quo_q, quo_d;
  logic signed [EW-1:0]     exp_q, exp_d;
  logic                     sign_q, sign_d;
  logic [FW-1:0]            result_q, result_d;
  logic                     zero_q, zero_d;
  logic                     divz_q, divz_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;

  // Combinational helpers for the CALC and NORM steps
  logic [QW-1:0]            rem_sub;
  logic                     q_bit;
  logic [MAN_W-1:0]         man_n;
  logic signed [EW-1:0]     exp_n;
  logic                     sign_in;

  assign sign_in = A[FW-1] ^ B[FW-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    result_d = result_q;
    zero_d   = zero_q;
    divz_d   = divz_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    rem_sub  = rem_q;
    q_bit    = 1'b0;
    man_n    = '0;
    exp_n    = exp_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d = sign_in;
          exp_d  = signed'(EW'(A[FW-2 -: EXP_W])) - signed'(EW'(B[FW-2 -: EXP_W])) + E_BIAS;
          rem_d  = {1'b0, 1'b1, A[MAN_W-1:0]};
          div_d  = {1'b1, B[MAN_W-1:0]};
          quo_d  = '0;
          cnt_d  = '0;
          zero_d = 1'b0;
          divz_d = 1'b0;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          if (B[FW-2 -: EXP_W] == '0) begin
            result_d = {sign_in, EXP_INF, {MAN_W{1'b0}}};
            divz_d   = 1'b1;
            state_d  = S_DONE;
          end else if (A[FW-2 -: EXP_W] == '0) begin
            result_d = {sign_in, {(FW-1){1'b0}}};
            zero_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end

      S_CALC: begin
        // One restoring step; quotient bits shift in at the LSB so the first
        // bit produced lands in the MSB after the final step.
        if (rem_q >= {1'b0, div_q}) begin
          rem_sub = rem_q - {1'b0, div_q};
          q_bit   = 1'b1;
        end
        rem_d = rem_sub << 1;
        quo_d = {quo_q[QW-2:0], q_bit};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_STEP) begin
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        // Quotient of two [1,2) mantissas lies in (0.5,2): at most one
        // left shift is ever needed.
        if (quo_q[QW-1]) begin
          man_n = quo_q[QW-2:1];
          exp_n = exp_q;
        end else begin
          man_n = quo_q[MAN_W-1:0];
          exp_n = exp_q - E_ONE;
        end
        zero_d = 1'b0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (exp_n >= E_SAT) begin
          result_d = {sign_q, EXP_INF, {MAN_W{1'b0}}};
          ovf_d    = 1'b1;
        end else if (exp_n <= E_ZERO) begin
          result_d = {sign_q, {(FW-1){1'b0}}};
          unf_d    = 1'b1;
          zero_d   = 1'b1;
        end else begin
          result_d = {sign_q, exp_n[EXP_W-1:0], man_n};
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      divz_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      divz_q   <= divz_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign DivZero   = divz_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_fp16_div_seq.sv
// ---------------------------------------------------------------------------
// tb_fp16_div_seq
//   Scoreboard bench for fp16_div_seq. Each accepted start pushes the
//   expected quotient, flags and latency computed by an arithmetic reference
//   model; a negedge monitor pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_fp16_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A, B;
  logic        busy, done;
  logic [15:0] Result;
  logic        Zero, DivZero, Overflow, Underflow;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] res;
    logic        z, dz, ov, uf;
    int          lat;
    int          t0;
    logic [15:0] a, b;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  fp16_div_seq dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Result(Result), .Zero(Zero),
    .DivZero(DivZero), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: value-level division of the two significands, then normalise.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int ea, eb, ma, mb, qq, man, ex;
    logic sr;
    sr = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    e.a = a; e.b = b;
    e.z = 0; e.dz = 0; e.ov = 0; e.uf = 0; e.t0 = 0;
    if (eb == 0) begin
      e.res = {sr, 15'h7C00}; e.dz = 1; e.lat = 1;
    end else if (ea == 0) begin
      e.res = {sr, 15'h0}; e.z = 1; e.lat = 1;
    end else begin
      e.lat = 14;
      ma = 1024 + int'(a[9:0]);
      mb = 1024 + int'(b[9:0]);
      qq = (ma * 2048) / mb;          // ma/mb with 11 fraction bits, truncated
      ex = ea - eb + 15;
      if (qq >= 2048) man = (qq / 2) % 1024;
      else begin man = qq % 1024; ex = ex - 1; end
      if (ex >= 31) begin
        e.res = {sr, 15'h7C00}; e.ov = 1;
      end else if (ex <= 0) begin
        e.res = {sr, 15'h0}; e.uf = 1; e.z = 1;
      end else begin
        e.res = {sr, 5'(ex), 10'(man)};
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL spurious_done got=1 want=0 Result=%h", Result);
      end else begin
        mon_e = sb.pop_front();
        $display("[TB] %h / %h -> %h z=%b dz=%b ov=%b uf=%b (exp %h) lat=%0d",
                 mon_e.a, mon_e.b, Result, Zero, DivZero, Overflow, Underflow,
                 mon_e.res, cyc - mon_e.t0);
        chk("result", 32'(Result), 32'(mon_e.res));
        chk("flags", 32'({Zero, DivZero, Overflow, Underflow}),
            32'({mon_e.z, mon_e.dz, mon_e.ov, mon_e.uf}));
        chk("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
        chk("busy_at_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e = model(a, b);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL done_timeout got=no_done want=done pending=%0d", sb.size());
      sb.delete();
    end
    @(negedge clk);
    chk("idle_after_done", 32'({busy, done}), 32'd0);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b);
    issue(a, b);
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({busy, done, Result, Zero, DivZero, Overflow, Underflow}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run(16'h3C00, 16'h3C00);
    run(16'h4600, 16'h4000);
    run(16'h3C00, 16'h4200);
    run(16'hC000, 16'h3800);
    run(16'h4000, 16'hB800);
    run(16'h3C00, 16'h0000);
    run(16'h0000, 16'h4000);
    run(16'h8000, 16'h0000);
    run(16'h7800, 16'h0400);
    run(16'h0400, 16'h7800);

    // Randomised operands, with occasional zero exponents
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 9) == 0) ra[14:10] = 5'd0;
      if ($urandom_range(0, 9) == 0) rb[14:10] = 5'd0;
      run(ra, rb);
    end

    // Start while busy is ignored; changing operands has no effect
    issue(16'h3C00, 16'h4200);
    repeat (3) @(negedge clk);
    A = 16'h7800; B = 16'h0400; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 16'h1234; B = 16'h5678;
    wait_idle();
    repeat (5) @(negedge clk);

    // Reset during CALC step 5 aborts with no done
    issue(16'h4600, 16'h4000);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_state",
        32'({busy, done, Result, Zero, DivZero, Overflow, Underflow}), 32'd0);
    sb.delete();
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Fresh operation after abort
    run(16'h3C00, 16'h4200);
    run(16'h4600, 16'h4000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
